// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment time reader: glyph codes (active-low, g..a),
// field widths and the reader FSM state encoding.
package seg_pkg;

    localparam int GLYPH_W = 7;
    localparam int NUM_DIG = 6;
    localparam int DIG_W   = 4;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOU_W   = 5;

    localparam logic [GLYPH_W-1:0] GLYPH_0     = 7'h40;
    localparam logic [GLYPH_W-1:0] GLYPH_1     = 7'h79;
    localparam logic [GLYPH_W-1:0] GLYPH_2     = 7'h24;
    localparam logic [GLYPH_W-1:0] GLYPH_3     = 7'h30;
    localparam logic [GLYPH_W-1:0] GLYPH_4     = 7'h19;
    localparam logic [GLYPH_W-1:0] GLYPH_5     = 7'h12;
    localparam logic [GLYPH_W-1:0] GLYPH_6     = 7'h02;
    localparam logic [GLYPH_W-1:0] GLYPH_7     = 7'h78;
    localparam logic [GLYPH_W-1:0] GLYPH_8     = 7'h00;
    localparam logic [GLYPH_W-1:0] GLYPH_9     = 7'h10;
    localparam logic [GLYPH_W-1:0] GLYPH_BLANK = 7'h7F;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // Kept at 7 bits so that range checks see the full two-digit value (up to 99).
    function automatic logic [6:0] tens_units(input logic [DIG_W-1:0] tens,
                                              input logic [DIG_W-1:0] units);
        return 7'(tens) * 7'd10 + 7'(units);
    endfunction

endpackage

// File: rtl/seg_time_reader_if.sv
// Time-word handshake between the segment reader and its consumer.
interface seg_time_reader_if;
    import seg_pkg::*;

    logic             ready;
    logic             valid;
    logic [SEC_W-1:0] sec;
    logic [MIN_W-1:0] min;
    logic [HOU_W-1:0] hou;
    logic             err;

    modport master (input  ready, output valid, sec, min, hou, err);
    modport slave  (output ready, input  valid, sec, min, hou, err);

endinterface

// File: rtl/seg_time_reader_seg7_dec.sv
// Combinational seven-segment glyph decoder; blank is accepted only when blank_ok is set.
module seg7_dec
    import seg_pkg::*;
(
    input  logic [GLYPH_W-1:0] glyph,
    input  logic               blank_ok,
    output logic [DIG_W-1:0]   digit,
    output logic               legal
);

    always_comb begin
        digit = '0;
        legal = 1'b1;
        case (glyph)
            GLYPH_0:     digit = 4'd0;
            GLYPH_1:     digit = 4'd1;
            GLYPH_2:     digit = 4'd2;
            GLYPH_3:     digit = 4'd3;
            GLYPH_4:     digit = 4'd4;
            GLYPH_5:     digit = 4'd5;
            GLYPH_6:     digit = 4'd6;
            GLYPH_7:     digit = 4'd7;
            GLYPH_8:     digit = 4'd8;
            GLYPH_9:     digit = 4'd9;
            GLYPH_BLANK: legal = blank_ok;
            default:     legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_time_reader.sv
// Reads a six-digit seven-segment clock display, waits for it to settle, and emits
// hh:mm:ss as binary fields over a valid/ready handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for STABLE_CYC identical samples, then snapshot
// SCAN     | decoding one snapshot digit per cycle, HEX0 first
// CHECK    | form fields, range-check, decide whether the word is new
// HOLD     | word presented; frozen until valid&ready
module seg_time_reader
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic               CLK,
    input  logic               clr_n,
    input  logic [GLYPH_W-1:0] HEX0,
    input  logic [GLYPH_W-1:0] HEX1,
    input  logic [GLYPH_W-1:0] HEX2,
    input  logic [GLYPH_W-1:0] HEX3,
    input  logic [GLYPH_W-1:0] HEX4,
    input  logic [GLYPH_W-1:0] HEX5,
    seg_time_reader_if.master  tw
);

    localparam logic [7:0] STABLE_TC = 8'(STABLE_CYC);

    logic [NUM_DIG*GLYPH_W-1:0] live;
    logic [NUM_DIG*GLYPH_W-1:0] smp;
    logic [NUM_DIG*GLYPH_W-1:0] snap;
    logic [7:0]                 stab_cnt;

    state_t                     state;
    logic [2:0]                 idx;
    logic [DIG_W-1:0]           dig [NUM_DIG];
    logic                       bad;
    logic                       emitted;

    logic [GLYPH_W-1:0]         cur_glyph;
    logic [DIG_W-1:0]           cur_digit;
    logic                       cur_legal;

    logic [6:0]                 sec_full;
    logic [6:0]                 min_full;
    logic [6:0]                 hou_full;
    logic                       err_c;
    logic [SEC_W-1:0]           sec_c;
    logic [MIN_W-1:0]           min_c;
    logic [HOU_W-1:0]           hou_c;
    logic                       new_result;

    logic                       valid_q;
    logic [SEC_W-1:0]           sec_q;
    logic [MIN_W-1:0]           min_q;
    logic [HOU_W-1:0]           hou_q;
    logic                       err_q;

    assign live = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    // Stability tracking runs in every state so a settled display is ready on return to IDLE.
    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            smp      <= {NUM_DIG{GLYPH_BLANK}};
            stab_cnt <= '0;
        end else begin
            smp <= live;
            if (live != smp)
                stab_cnt <= '0;
            else if (stab_cnt != STABLE_TC)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    always_comb begin
        case (idx)
            3'd0:    cur_glyph = snap[0*GLYPH_W +: GLYPH_W];
            3'd1:    cur_glyph = snap[1*GLYPH_W +: GLYPH_W];
            3'd2:    cur_glyph = snap[2*GLYPH_W +: GLYPH_W];
            3'd3:    cur_glyph = snap[3*GLYPH_W +: GLYPH_W];
            3'd4:    cur_glyph = snap[4*GLYPH_W +: GLYPH_W];
            default: cur_glyph = snap[5*GLYPH_W +: GLYPH_W];
        endcase
    end

    seg7_dec u_dec (
        .glyph    (cur_glyph),
        .blank_ok (idx == 3'd5),
        .digit    (cur_digit),
        .legal    (cur_legal)
    );

    assign sec_full = tens_units(dig[1], dig[0]);
    assign min_full = tens_units(dig[3], dig[2]);
    assign hou_full = tens_units(dig[5], dig[4]);
    assign err_c    = bad || (sec_full > 7'd59) || (min_full > 7'd59) || (hou_full > 7'd23);
    assign sec_c    = sec_full[SEC_W-1:0];
    assign min_c    = min_full[MIN_W-1:0];
    assign hou_c    = hou_full[HOU_W-1:0];

    // The output registers double as the record of the last emitted word.
    assign new_result = !emitted || ({sec_c, min_c, hou_c, err_c} != {sec_q, min_q, hou_q, err_q});

    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            state   <= ST_IDLE;
            snap    <= {NUM_DIG{GLYPH_BLANK}};
            idx     <= '0;
            bad     <= 1'b0;
            emitted <= 1'b0;
            valid_q <= 1'b0;
            sec_q   <= '0;
            min_q   <= '0;
            hou_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++)
                dig[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stab_cnt == STABLE_TC) begin
                        snap  <= smp;
                        idx   <= '0;
                        bad   <= 1'b0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    dig[idx] <= cur_legal ? cur_digit : '0;
                    bad      <= bad | ~cur_legal;
                    if (idx == 3'd5)
                        state <= ST_CHECK;
                    else
                        idx <= idx + 3'd1;
                end
                ST_CHECK: begin
                    if (new_result) begin
                        sec_q   <= sec_c;
                        min_q   <= min_c;
                        hou_q   <= hou_c;
                        err_q   <= err_c;
                        valid_q <= 1'b1;
                        emitted <= 1'b1;
                        state   <= ST_HOLD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (tw.ready) begin
                        valid_q <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tw.valid = valid_q;
    assign tw.sec   = sec_q;
    assign tw.min   = min_q;
    assign tw.hou   = hou_q;
    assign tw.err   = err_q;

endmodule

// File: tb/tb_seg_time_reader.sv
// Bench for seg_time_reader: directed scenarios with literal expectations plus
// randomized display traffic checked every cycle against a transaction-level model.
module tb_seg_time_reader;

    localparam int STABLE_CYC = 4;

    logic        CLK   = 1'b0;
    logic        clr_n = 1'b1;
    logic [41:0] hexv;

    int n_cmp     = 0;
    int n_fail    = 0;
    int dut_xfers = 0;
    int m_xfers   = 0;

    logic [6:0] GL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg_time_reader_if tw ();

    seg_time_reader #(.STABLE_CYC(STABLE_CYC)) dut (
        .CLK   (CLK),
        .clr_n (clr_n),
        .HEX0  (hexv[6:0]),
        .HEX1  (hexv[13:7]),
        .HEX2  (hexv[20:14]),
        .HEX3  (hexv[27:21]),
        .HEX4  (hexv[34:28]),
        .HEX5  (hexv[41:35]),
        .tw    (tw)
    );

    always #5 CLK = ~CLK;

    function automatic logic [17:0] word(input int s, input int m, input int h, input bit e);
        return {6'(s), 6'(m), 5'(h), e};
    endfunction

    function automatic logic [41:0] glyphs_of(input int h, input int m, input int s);
        return {GL[h / 10], GL[h % 10], GL[m / 10], GL[m % 10], GL[s / 10], GL[s % 10]};
    endfunction

    // Reference decode of a whole snapshot straight from the display rules.
    function automatic logic [17:0] eval_snap(input logic [41:0] snap);
        int d [6];
        bit bad;
        bit ok;
        int sv, mv, hv;
        logic [6:0] g;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            g    = snap[7*i +: 7];
            d[i] = 0;
            ok   = 1'b0;
            for (int k = 0; k < 10; k++)
                if (g == GL[k]) begin
                    d[i] = k;
                    ok   = 1'b1;
                end
            if (i == 5 && g == 7'h7F) ok = 1'b1;
            if (!ok) bad = 1'b1;
        end
        sv = 10 * d[1] + d[0];
        mv = 10 * d[3] + d[2];
        hv = 10 * d[5] + d[4];
        if (sv > 59 || mv > 59 || hv > 23) bad = 1'b1;
        return word(sv, mv, hv, bad);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a snapshot is taken once the display has been stable long enough and the
    // reader is free; the word follows 7 cycles later if it differs from the last one.
    logic [41:0] m_smp;
    logic [41:0] m_snap;
    int          m_cnt;
    int          m_busy;
    bit          m_valid;
    bit          m_emitted;
    logic [17:0] m_word;
    logic [17:0] m_res;

    always @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            m_smp     = {6{7'h7F}};
            m_snap    = '0;
            m_cnt     = 0;
            m_busy    = 0;
            m_valid   = 1'b0;
            m_emitted = 1'b0;
            m_word    = '0;
        end else begin
            if (m_valid) begin
                if (tw.ready) begin
                    m_valid = 1'b0;
                    m_xfers++;
                end
            end else if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_res = eval_snap(m_snap);
                    if (!m_emitted || m_res != m_word) begin
                        m_word    = m_res;
                        m_valid   = 1'b1;
                        m_emitted = 1'b1;
                    end
                end
            end else if (m_cnt >= STABLE_CYC) begin
                m_snap = m_smp;
                m_busy = 7;
            end
            if (hexv != m_smp) m_cnt = 0;
            else if (m_cnt < STABLE_CYC) m_cnt++;
            m_smp = hexv;
        end
    end

    always @(negedge CLK) begin
        if (clr_n) begin
            check("valid", 32'(tw.valid), 32'(m_valid));
            if (m_valid)
                check("word", 32'({tw.sec, tw.min, tw.hou, tw.err}), 32'(m_word));
        end
    end

    logic [17:0] got [$];
    always @(posedge CLK) begin
        if (clr_n && tw.valid && tw.ready) begin
            dut_xfers++;
            got.push_back({tw.sec, tw.min, tw.hou, tw.err});
        end
    end

    task automatic wait_xfer(input string name, input int budget, output logic [17:0] w);
        int n0;
        n0 = dut_xfers;
        w  = '0;
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #1;
            if (dut_xfers > n0) begin
                w = got[got.size() - 1];
                return;
            end
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: no transfer within %0d cycles", name, budget);
    endtask

    task automatic wait_valid(input string name, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge CLK);
            #1;
            if (tw.valid) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL %s: valid not seen within %0d cycles", name, budget);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] w;
        int lat;
        int n0;
        logic [6:0] g;
        int r;
        int dur;

        hexv     = {6{7'h7F}};
        tw.ready = 1'b1;
        #1 clr_n = 1'b0;
        #1;
        check("reset_valid", 32'(tw.valid), 32'd0);
        check("reset_word", 32'({tw.sec, tw.min, tw.hou, tw.err}), 32'd0);

        // 12:34:56 settled before release; the first edge samples it.
        hexv = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};
        @(negedge CLK);
        @(negedge CLK);
        clr_n = 1'b1;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (tw.valid) begin
                lat = k;
                break;
            end
        end
        // Sampling edge plus STABLE_CYC+8 further cycles.
        check("first_latency", 32'(lat), 32'(STABLE_CYC + 9));
        wait_xfer("xfer_123456", 5, w);
        check("word_123456", 32'(w), 32'(word(56, 34, 12, 0)));

        n0 = dut_xfers;
        repeat (100) @(posedge CLK);
        #1;
        check("no_repeat_word", 32'(dut_xfers - n0), 32'd0);

        @(negedge CLK);
        hexv[6:0] = 7'h40;
        wait_xfer("xfer_sec50", 40, w);
        check("word_sec50", 32'(w), 32'(word(50, 34, 12, 0)));
        @(negedge CLK);
        hexv[13:7] = 7'h02;
        wait_xfer("xfer_sec60", 40, w);
        check("word_sec60_err", 32'(w), 32'(word(60, 34, 12, 1)));

        // Consumer stalls while the display keeps moving.
        @(negedge CLK);
        tw.ready = 1'b0;
        hexv = glyphs_of(1, 2, 3);
        wait_valid("hold_valid", 40);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (k % 3 == 0) hexv[6:0] = GL[(k / 3) % 10];
            #1;
            check("hold_frozen", 32'({tw.valid, tw.sec, tw.min, tw.hou, tw.err}),
                  32'({1'b1, word(3, 2, 1, 0)}));
        end
        @(negedge CLK);
        tw.ready = 1'b1;
        wait_xfer("xfer_held", 5, w);
        check("word_held", 32'(w), 32'(word(3, 2, 1, 0)));
        wait_xfer("xfer_after_hold", 40, w);
        check("word_after_hold", 32'(w), 32'(word(6, 2, 1, 0)));

        // HEX2 never stable for STABLE_CYC samples.
        repeat (30) @(posedge CLK);
        n0 = dut_xfers;
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            if (k % 2 == 0) hexv[20:14] = (k % 4 == 0) ? 7'h12 : 7'h02;
        end
        check("toggle_no_valid", 32'(dut_xfers - n0), 32'd0);
        wait_xfer("xfer_after_toggle", 40, w);
        check("word_after_toggle", 32'(w), 32'(word(6, 6, 1, 0)));

        @(negedge CLK);
        hexv = {7'h7F, 7'h40, 7'h19, 7'h12, 7'h79, 7'h40};
        wait_xfer("xfer_blank_hex5", 40, w);
        check("word_blank_hex5", 32'(w), 32'(word(10, 45, 0, 0)));
        @(negedge CLK);
        hexv[27:21] = 7'h7F;
        wait_xfer("xfer_blank_hex3", 40, w);
        check("word_blank_hex3", 32'(w), 32'(word(10, 5, 0, 1)));

        // Reset in the middle of a scan.
        @(negedge CLK);
        hexv = glyphs_of(23, 59, 58);
        repeat (STABLE_CYC + 4) @(posedge CLK);
        @(negedge CLK);
        clr_n = 1'b0;
        #1;
        check("midscan_rst_valid", 32'(tw.valid), 32'd0);
        check("midscan_rst_word", 32'({tw.sec, tw.min, tw.hou, tw.err}), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        clr_n = 1'b1;
        wait_xfer("xfer_after_rst", 40, w);
        check("word_after_rst", 32'(w), 32'(word(58, 59, 23, 0)));

        // Reset while holding an unaccepted word.
        @(negedge CLK);
        tw.ready = 1'b0;
        hexv = glyphs_of(7, 8, 9);
        wait_valid("hold_before_rst", 40);
        @(negedge CLK);
        clr_n = 1'b0;
        #1;
        check("midhold_rst_valid", 32'(tw.valid), 32'd0);
        @(negedge CLK);
        tw.ready = 1'b1;
        clr_n = 1'b1;
        n0 = dut_xfers;
        wait_xfer("xfer_after_hold_rst", 40, w);
        check("word_after_hold_rst", 32'(w), 32'(word(9, 8, 7, 0)));
        repeat (40) @(posedge CLK);
        #1;
        check("single_xfer_after_rst", 32'(dut_xfers - n0), 32'd1);

        // Random display traffic with a random consumer.
        for (int seg = 0; seg < 200; seg++) begin
            @(negedge CLK);
            for (int i = 0; i < 6; i++) begin
                r = $urandom_range(0, 19);
                if (r < 17) g = GL[$urandom_range(0, (i == 5) ? 2 : ((i % 2 == 1) ? 6 : 9))];
                else if (r == 17) g = 7'h7F;
                else g = 7'($urandom);
                hexv[7*i +: 7] = g;
            end
            tw.ready = ($urandom_range(0, 3) != 0);
            dur = $urandom_range(1, 14);
            for (int k = 1; k < dur; k++) begin
                @(negedge CLK);
                tw.ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge CLK);
        tw.ready = 1'b1;
        repeat (60) @(posedge CLK);
        #1;
        check("xfer_count", 32'(dut_xfers), 32'(m_xfers));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_time_reader.md
SEG_TIME_READER -- requirements
Module: seg_time_reader

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, meaning the number of consecutive identical input samples required before decoding (legal 1..255).
REQ-002 SHALL have port CLK  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port clr_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports HEX0..HEX5  in  7 each  active-low segment buses, bit0=a … bit6=g, where 0 means lit; HEX1:HEX0 = seconds, HEX3:HEX2 = minutes, HEX5:HEX4 = hours (tens:units).
REQ-005 SHALL have port ready  in  1  consumer accepts the time word.
REQ-006 SHALL have port valid  out  1  time word available.
REQ-007 SHALL have ports sec  out  6, min  out  6, hou  out  5, each a binary decoded value.
REQ-008 SHALL have port err  out  1  qualifies valid: 1 means the snapshot contained an illegal glyph or an out-of-range field.

Function
REQ-009 SHALL register all six buses in one input stage and compare each sample with the previous one; any difference SHALL reset the stability counter to 0.
REQ-010 SHALL use the FSM states IDLE, SCAN, CHECK, HOLD.
REQ-011 SHALL take IDLE->SCAN when the stability counter reaches STABLE_CYC, copying the 42-bit sample into a snapshot register in that cycle.
REQ-012 SHALL, in SCAN, decode one digit per cycle from the snapshot (order HEX0..HEX5, 6 cycles) and ignore live inputs meanwhile.
REQ-013 SHALL, in CHECK (1 cycle), compute sec=10*HEX1+HEX0, min=10*HEX3+HEX2, hou=10*HEX5+HEX4, and set err if any glyph is illegal, sec>59, min>59, or hou>23.
REQ-014 SHALL go CHECK->HOLD when the result (value,err) differs from the last emitted result or nothing has been emitted since reset; otherwise CHECK->IDLE with no output.
REQ-015 SHALL raise valid on entry to HOLD and keep valid, sec, min, hou, err constant until a cycle with valid&ready; that cycle SHALL be the transfer, after which the FSM returns to IDLE and valid drops the following cycle.
REQ-016 SHALL produce first valid exactly STABLE_CYC+8 cycles after the last input change, when ready is held high.
REQ-017 SHALL accept only these legal glyphs (hex, g..a): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10; blank (7F) SHALL be legal only on HEX5 (decoded 0); every other pattern SHALL be illegal.
REQ-018 SHALL keep comparing and counting stability on inputs that change during SCAN/CHECK/HOLD; the counter SHALL saturate at STABLE_CYC, and a pending stable snapshot SHALL be taken on return to IDLE.
REQ-019 SHALL, when an erroneous result is emitted, hold sec/min/hou at the partially decoded values, with illegal digits read as 0.

Reset
REQ-020 SHALL, when clr_n=0, immediately force state IDLE, valid=0, err=0, sec=min=hou=0, stability counter=0, input stage=7F on all digits, and the "emitted" flag cleared.
REQ-021 SHALL, on reset mid-SCAN or mid-HOLD, discard the transaction, and SHALL leave no transfer pending after release.

Structure
REQ-022 SHALL place the glyph constants (ten digits plus blank), the FSM state enum and the digit/time field widths in shared package seg_pkg.
REQ-023 SHALL use one combinational sub-module seg7_dec (7-bit glyph in; 4-bit digit plus legal flag out, with a blank_ok input), instantiated once and muxed by scan index.

Verification
REQ-024 SHALL cover: HEX5..0 = 79,24,30,19,12,02 held, ready=1 -> valid after STABLE_CYC+8 cycles with hou=12, min=34, sec=56, err=0, one transfer.
REQ-025 SHALL cover: same pattern held 100 more cycles -> no further valid.
REQ-026 SHALL cover: HEX1 = 12 with HEX0 = 40 (sec 50), then HEX1 changed to 02 (sec "60") -> first word sec=50, err=0; second word err=1.
REQ-027 SHALL cover: ready=0 during HOLD for 20 cycles while inputs change -> outputs frozen; after ready the new value is emitted with no loss.
REQ-028 SHALL cover: HEX2 toggling every 2 cycles with STABLE_CYC=4 -> valid never rises; blank on HEX5 with 0x40 on HEX4 -> hou=0, err=0; blank on HEX3 -> err=1.
REQ-029 SHALL cover: clr_n pulsed low mid-SCAN -> valid=0 and all outputs 0 within the same cycle; the unchanged input is re-emitted after release.
